// File: rtl/vga_fb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// vga_fb_arbiter : shares the framebuffer SPRAM port between the CPU window
//                  and the display pixel fetch, with a bounded CPU stall.
// Revision: 1.0
// ============================================================================
module vga_fb_arbiter #(
    parameter int AW        = 14,
    parameter int MAX_STALL = 8,
    parameter int SW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel,
    input  logic [3:0]    wstrb,
    input  logic [23:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic [31:0]   rdata,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic          disp_rvalid,
    output logic [31:0]   disp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUED  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_t;

    localparam logic [SW-1:0] c_stall_max = SW'(MAX_STALL);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   disp_rdata_q, disp_rdata_d;
    logic          disp_rvalid_q, disp_rvalid_d;

    logic          w_cpu_pend;
    logic          w_disp_gnt;
    logic          w_cpu_gnt;
    logic          w_cpu_rd;
    logic [AW-1:0] w_cpu_widx;
    logic          w_unused_addr_bits;

    assign w_cpu_widx         = addr[AW+1:2];
    assign w_unused_addr_bits = &{1'b0, addr[23:AW+2], addr[1:0]};
    assign w_cpu_rd           = (wstrb == 4'b0000);
    assign w_cpu_pend         = (state_q == ST_IDLE) && sel;
    // Display wins unless the CPU has already lost MAX_STALL cycles in a row.
    assign w_disp_gnt         = disp_req && !(w_cpu_pend && (stall_q == c_stall_max));
    assign w_cpu_gnt          = w_cpu_pend && !w_disp_gnt;

    always_comb begin
        state_d       = state_q;
        owner_d       = OWN_NONE;
        stall_d       = stall_q;
        rdata_d       = rdata_q;
        disp_rdata_d  = disp_rdata_q;
        disp_rvalid_d = w_disp_gnt;

        case (state_q)
            ST_IDLE:    if (w_cpu_gnt) state_d = ST_ISSUED;
            ST_ISSUED:  state_d = ST_HOLDOFF;
            ST_HOLDOFF: if (!sel) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (w_disp_gnt)
            owner_d = OWN_DISP;
        else if (w_cpu_gnt && w_cpu_rd)
            owner_d = OWN_CPU;

        if (w_cpu_gnt || !sel)
            stall_d = '0;
        else if (w_cpu_pend && w_disp_gnt && (stall_q != c_stall_max))
            stall_d = stall_q + SW'(1);

        // The owner tag is single-valued, so only one capture path loads.
        if (owner_q == OWN_CPU)
            rdata_d = mem_rdata;
        if (owner_q == OWN_DISP)
            disp_rdata_d = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_NONE;
            stall_q       <= '0;
            rdata_q       <= '0;
            disp_rdata_q  <= '0;
            disp_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            stall_q       <= stall_d;
            rdata_q       <= rdata_d;
            disp_rdata_q  <= disp_rdata_d;
            disp_rvalid_q <= disp_rvalid_d;
        end
    end

    assign ready       = (state_q == ST_ISSUED);
    assign rdata       = (owner_q == OWN_CPU)  ? mem_rdata : rdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = (owner_q == OWN_DISP) ? mem_rdata : disp_rdata_q;
    assign disp_ack    = w_disp_gnt && !reset;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        mem_we    = 1'b0;
        if (!reset) begin
            if (w_disp_gnt) begin
                mem_addr = disp_addr;
            end else if (w_cpu_gnt) begin
                mem_addr  = w_cpu_widx;
                mem_we    = !w_cpu_rd;
                mem_wmask = wstrb;
                mem_wdata = wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares the single VGA framebuffer SPRAM port between two requesters:
  - the CPU iomem window (sel/ready/wstrb/addr/wdata/rdata, high-bit-decoded slave);
  - the pixel-fetch engine, which reads scanline words.
- Display has priority. A bounded-stall guard ensures the CPU always makes progress.
- Sits inside the vga core, between the bus-side registers and the ice40up5k SPRAM macro.

Parameters:
- AW, 14, framebuffer word-address width (16K x 32-bit words).
- MAX_STALL, 8, max consecutive cycles a pending CPU access may lose to display before a forced CPU grant.
- SW, 4, stall counter width; must satisfy 2^SW > MAX_STALL.

Ports:
- clk  in  1  system clock (the SoC clock, clk2 domain)
- reset  in  1  asynchronous, active-high reset
- sel  in  1  CPU access request; level, held until ready is seen
- wstrb  in  4  CPU byte write strobes; 0000 = read
- addr  in  24  CPU byte address; word index = addr[AW+1:2]
- wdata  in  32  CPU write data
- ready  out  1  one-cycle CPU completion pulse
- rdata  out  32  CPU read data, valid while ready=1 and held until the next CPU access completes
- disp_req  in  1  display fetch request, level
- disp_addr  in  AW  display word address
- disp_ack  out  1  combinational: display granted this cycle
- disp_rvalid  out  1  display read data valid, one cycle after disp_ack
- disp_rdata  out  32  display read data
- mem_addr  out  AW  SPRAM word address (combinational from grant)
- mem_wdata  out  32  SPRAM write data
- mem_wmask  out  4  SPRAM byte write mask
- mem_we  out  1  SPRAM write enable
- mem_rdata  in  32  SPRAM read data, one cycle after address

Behaviour:
- Reset (async):
  - ready=0, rdata=0, disp_rvalid=0, disp_rdata=0.
  - stall_cnt=0, state=IDLE, rd_owner=none.
  - The mem_* outputs are 0 while reset is high.
- CPU state machine:
  - IDLE: cpu_pend = sel. On CPU grant, issue the access and go to ISSUED.
  - ISSUED (exactly 1 cycle):
    - ready=1.
    - For a read, rdata <= mem_rdata. For a write, rdata is unchanged.
    - Go to HOLDOFF.
  - HOLDOFF: ignore sel; return to IDLE on the first cycle sel=0. This absorbs the parent's registered ready path, which keeps sel high for 2 more cycles.
- Arbitration, per cycle:
  - Only one SPRAM access per cycle; grant is combinational.
  - Display is granted when disp_req=1, unless cpu_pend=1 and stall_cnt==MAX_STALL. In that case the CPU is granted and disp_ack=0.
  - CPU is granted when cpu_pend=1 and the display is not granted.
  - Neither requester: mem_we=0, mem_addr=0.
- stall_cnt:
  - Increments on each cycle with cpu_pend=1 and a display grant, saturating at MAX_STALL.
  - Clears on CPU grant, and when sel drops.
- Access encoding:
  - CPU write (wstrb!=0): mem_we=1, mem_wmask=wstrb, mem_wdata=wdata.
  - CPU read: mem_we=0, mem_wmask=0.
  - Display grant: mem_we=0, mem_addr=disp_addr.
- Latencies:
  - CPU: ready asserts exactly 1 cycle after the grant cycle, for both reads and writes.
  - Display: disp_rvalid=1 and disp_rdata=mem_rdata exactly 1 cycle after disp_ack.
  - Back-to-back display grants yield back-to-back disp_rvalid.
- Read-data routing: a registered rd_owner tag selects where mem_rdata goes. The CPU and display capture paths must never both load from the same cycle.
- Address bits above AW+1 are ignored (aliasing wraps within the framebuffer). addr[1:0] is ignored.
- Simultaneous first-cycle requests: display wins while stall_cnt < MAX_STALL.
- Worst-case CPU latency under continuous display traffic: MAX_STALL+1 cycles from sel to ready.
- Reset mid-operation:
  - Any in-flight ready or disp_rvalid is suppressed.
  - After release, the FSM is in IDLE, so a sel still high is treated as a new request.

Test Plan:
- CPU write 0x12345678, addr=0x000010, wstrb=1111, no display traffic -> mem_addr=4, mem_we=1, mem_wmask=1111 in grant cycle; ready pulse next cycle. Read back same addr -> rdata=0x12345678 with ready 1 cycle after grant.
- Byte write wstrb=0010, wdata=0x0000AB00 to addr 0x10 -> mem_wmask=0010. Readback = 0x1234AB78.
- disp_req held high continuously, CPU read issued at cycle 0 -> disp_ack high cycles 0..7. Cycle 8: disp_ack=0, CPU granted. ready at cycle 9. Display regains cycle 9.
- sel held high 3 cycles after the ready pulse (parent-style registered ready) -> exactly one SPRAM access; no second ready; next access starts only after sel has been low ≥1 cycle.
- Interleaved traffic (display grant at cycle N, CPU read at N+1) -> disp_rvalid at N+1 carrying the display word; CPU rdata at N+2 carrying the CPU word; no cross-routing.
- Reset asserted in the ISSUED cycle of a CPU read -> ready=0 and rdata=0 immediately. After release with sel=1 -> fresh access, ready 1 cycle after the new grant.
